// File: rtl/jk_counter_driver_if.sv
// Handshake bundle between a controller and the JK excitation driver.
// The master drives the count controls and the bank feedback; the slave
// (the driver) returns the reference count, the excitation and the flags.
interface jk_counter_driver_if #(
    parameter int W = 4
);
    logic         En;
    logic         Up;
    logic         Load;
    logic [W-1:0] Din;
    logic         ChkEn;
    logic [W-1:0] Fb;
    logic [W-1:0] Cnt;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic         Tc;
    logic         Err;

    modport master (
        output En, Up, Load, Din, ChkEn, Fb,
        input  Cnt, J, K, Tc, Err
    );

    modport slave (
        input  En, Up, Load, Din, ChkEn, Fb,
        output Cnt, J, K, Tc, Err
    );
endinterface

// File: rtl/jk_counter_driver.sv
// Excitation driver for a bank of master-slave JK flip-flops. Keeps a
// reference modulo-MOD up/down count, derives per-bit J/K so an external
// bank clocked on the same Clk follows it, and flags feedback divergence.

// Per-bit excitation: set on a 0->1 transition, reset on 1->0, otherwise
// leave both inputs low so J and K are never asserted together.
module jk_exc_bit (
    input  logic q,
    input  logic n,
    input  logic clr,
    output logic j,
    output logic k
);
    // Pure transition decode, suppressed while the bank is being cleared.
    always_comb begin
        j = ~clr & ~q &  n;
        k = ~clr &  q & ~n;
    end
endmodule

module jk_counter_driver #(
    parameter int W   = 4,
    parameter int MOD = 10
) (
    input  logic                 Clk,
    input  logic                 Clr,
    jk_counter_driver_if.slave   bus
);
    // Modulus may equal 2^W, so the range compare needs one extra bit.
    localparam logic [W:0]   MOD_X = (W+1)'(MOD);
    localparam logic [W-1:0] TOP   = W'(MOD - 1);

    logic [W-1:0] cnt_q;
    logic         err_q;
    logic [W-1:0] nxt;
    logic [W-1:0] j_w;
    logic [W-1:0] k_w;

    // Next-count selection: load (with out-of-range clamp) beats enable.
    always_comb begin
        nxt = cnt_q;
        if (bus.Load) begin
            nxt = ({1'b0, bus.Din} < MOD_X) ? bus.Din : '0;
        end else if (bus.En) begin
            if (bus.Up) nxt = (cnt_q == TOP)   ? '0  : cnt_q + W'(1);
            else        nxt = (cnt_q == '0)    ? TOP : cnt_q - W'(1);
        end
    end

    // Reference count register; cleared asynchronously with the bank.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) cnt_q <= '0;
        else     cnt_q <= nxt;
    end

    // Sticky divergence flag; a load re-synchronises the bank so it clears.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr)                                   err_q <= 1'b0;
        else if (bus.Load)                         err_q <= 1'b0;
        else if (bus.ChkEn && (bus.Fb != cnt_q))   err_q <= 1'b1;
    end

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            jk_exc_bit u_exc (
                .q   (cnt_q[i]),
                .n   (nxt[i]),
                .clr (Clr),
                .j   (j_w[i]),
                .k   (k_w[i])
            );
        end
    endgenerate

    // Terminal count flags the wrap edge of an enabled, non-load cycle.
    always_comb begin
        bus.Tc  = bus.En & ~bus.Load &
                  ((bus.Up & (cnt_q == TOP)) | (~bus.Up & (cnt_q == '0)));
        bus.Cnt = cnt_q;
        bus.Err = err_q;
        bus.J   = j_w;
        bus.K   = k_w;
    end
endmodule

// File: tb/tb_jk_counter_driver.sv
// Randomised self-checking bench for jk_counter_driver against a
// behavioural modulo counter model.
module tb_jk_counter_driver;
    localparam int W   = 4;
    localparam int MOD = 10;

    logic Clk = 1'b0;
    logic Clr = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    int m_cnt = 0;
    bit m_err = 1'b0;

    jk_counter_driver_if #(.W(W)) bus ();

    jk_counter_driver #(.W(W), .MOD(MOD)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference next value in plain modular arithmetic.
    function automatic int model_next(input bit en, input bit up, input bit load, input int din);
        if (load)    return (din < MOD) ? din : 0;
        if (en && up)  return (m_cnt + 1) % MOD;
        if (en && !up) return (m_cnt + MOD - 1) % MOD;
        return m_cnt;
    endfunction

    // One clock cycle: drive, check combinational view at negedge, clock, update model.
    task automatic step(input bit en, input bit up, input bit load, input int din,
                        input bit chken, input int fb);
        int n;
        logic [W-1:0] cur, nv, ej, ek;
        bit etc;
        bus.En = en; bus.Up = up; bus.Load = load;
        bus.Din = W'(din); bus.ChkEn = chken; bus.Fb = W'(fb);
        @(negedge Clk);
        n = model_next(en, up, load, din);
        cur = W'(m_cnt);
        nv  = W'(n);
        ej = '0; ek = '0;
        for (int b = 0; b < W; b++) begin
            if (!cur[b] && nv[b]) ej[b] = 1'b1;
            if (cur[b] && !nv[b]) ek[b] = 1'b1;
        end
        etc = en && !load && (up ? (m_cnt == MOD-1) : (m_cnt == 0));
        chk("cnt", 32'(bus.Cnt), 32'(m_cnt));
        chk("err", 32'(bus.Err), 32'(m_err));
        chk("j",   32'(bus.J),   32'(ej));
        chk("k",   32'(bus.K),   32'(ek));
        chk("tc",  32'(bus.Tc),  32'(etc));
        @(posedge Clk);
        if (load) m_err = 1'b0;
        else if (chken && (fb != m_cnt)) m_err = 1'b1;
        m_cnt = n;
        #1;
    endtask

    // Mid-cycle asynchronous clear with inputs that would otherwise excite bits.
    task automatic clr_pulse();
        bus.En = 1'b1; bus.Up = 1'b1; bus.Load = 1'b0; bus.ChkEn = 1'b0;
        #1 Clr = 1'b1;
        #1;
        m_cnt = 0; m_err = 1'b0;
        chk("clr_cnt", 32'(bus.Cnt), 32'd0);
        chk("clr_err", 32'(bus.Err), 32'd0);
        chk("clr_j",   32'(bus.J),   32'd0);
        chk("clr_k",   32'(bus.K),   32'd0);
        #1 Clr = 1'b0;
    endtask

    initial begin
        bus.En = 0; bus.Up = 0; bus.Load = 0; bus.Din = '0; bus.ChkEn = 0; bus.Fb = '0;
        #3;
        chk("rst_cnt", 32'(bus.Cnt), 32'd0);
        chk("rst_err", 32'(bus.Err), 32'd0);
        chk("rst_j",   32'(bus.J),   32'd0);
        chk("rst_k",   32'(bus.K),   32'd0);
        bus.En = 1; bus.Up = 1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_hold_cnt", 32'(bus.Cnt), 32'd0);
        chk("rst_hold_j",   32'(bus.J),   32'd0);
        Clr = 1'b0;

        // Hold, then a full up cycle with matching feedback.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(1, 1, 0, 0, 1, m_cnt);
        chk("up_wrap", 32'(bus.Cnt), 32'd1);

        // Down wrap from zero.
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("down_wrap", 32'(bus.Cnt), 32'(MOD-1));
        step(1, 0, 0, 0, 0, 0);

        // Load priority and clamp.
        step(1, 1, 1, 5, 0, 0);
        chk("load5", 32'(bus.Cnt), 32'd5);
        step(1, 0, 1, 12, 0, 0);
        chk("load_clamp", 32'(bus.Cnt), 32'd0);
        step(0, 0, 1, 15, 0, 0);

        // Feedback mismatch is sticky until a load.
        step(0, 0, 1, 4, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, m_cnt);
        step(0, 0, 0, 0, 1, 3);
        chk("err_set", 32'(bus.Err), 32'd1);
        step(1, 1, 0, 0, 1, m_cnt);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 2, 1, 9);
        chk("err_load_clr", 32'(bus.Err), 32'd0);
        step(0, 0, 0, 0, 0, 0);

        // Async clear at count 7, then count resumes from 0.
        step(0, 0, 1, 7, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        clr_pulse();
        step(1, 1, 0, 0, 0, 0);
        chk("post_clr", 32'(bus.Cnt), 32'd1);

        // Randomised traffic with occasional mismatches and clears.
        for (int i = 0; i < 400; i++) begin
            bit en, up, ld, ce;
            int din, fb;
            en  = ($urandom_range(0, 3) != 0);
            up  = $urandom_range(0, 1);
            ld  = ($urandom_range(0, 9) == 0);
            din = $urandom_range(0, (1 << W) - 1);
            ce  = $urandom_range(0, 1);
            fb  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (1 << W) - 1) : m_cnt;
            if ($urandom_range(0, 49) == 0) clr_pulse();
            step(en, up, ld, din, ce, fb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
